// File: rtl/irq_pending_ctrl_if.sv
// Vector offer port of irq_pending_ctrl.
// The producer drives valid/id and the consumer drives ready.
interface irq_pending_ctrl_if;
  logic       vec_valid;
  logic [3:0] vec_id;
  logic       vec_ready;

  modport master (
    output vec_valid,
    output vec_id,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_id,
    output vec_ready
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// IRQ edge capture, pending register and vector dispatch around an external
// priority encoder. Optional input synchroniser: define IRQ_SYNC_EN.
module irq_pending_ctrl #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        req_in,
  input  logic [15:0]        mask,
  input  logic               clr_all,
  output logic [15:0]        enc_req,
  input  logic [7:0]         enc_code,
  irq_pending_ctrl_if.master vec,
  output logic [15:0]        pending,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE,
    LOOK,
    OFFER,
    HOLD
  } state_e;

  localparam logic [3:0] HoldLoad =
    (HOLDOFF == 0) ? 4'd0 : 4'(HOLDOFF - 1);

  state_e      state_q;
  logic [15:0] req_s;
  logic [15:0] req_prev_q;
  logic [15:0] rise;
  logic [15:0] acc_bits;
  logic [15:0] pending_q, pending_d;
  logic        overflow_q, overflow_d;
  logic        vec_valid_q;
  logic [3:0]  vec_id_q;
  logic [3:0]  hold_q;
  logic        accept;

`ifdef IRQ_SYNC_EN
  logic [15:0] sync1_q, sync2_q;

  // Shifts through reset too, like the edge detector history.
  always_ff @(posedge clk) begin
    sync1_q <= req_in;
    sync2_q <= sync1_q;
  end

  assign req_s = sync2_q;
`else
  assign req_s = req_in;
`endif

  // History is loaded during reset so lines high at release give no edge.
  always_ff @(posedge clk) begin
    req_prev_q <= req_s;
  end

  assign rise     = req_s & ~req_prev_q;
  assign accept   = vec_valid_q & vec.vec_ready;
  assign acc_bits = accept ? (16'd1 << vec_id_q) : 16'd0;

  always_comb begin
    pending_d  = (pending_q & ~acc_bits) | rise;
    overflow_d = overflow_q
               | (|(rise & pending_q & ~acc_bits));
    if (clr_all) begin
      pending_d  = 16'd0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= 16'd0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_valid_q <= 1'b0;
      vec_id_q    <= 4'd0;
      hold_q      <= 4'd0;
    end else if (clr_all) begin
      state_q     <= IDLE;
      vec_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|enc_req) state_q <= LOOK;
        end
        LOOK: begin
          if (enc_code[7:4] == 4'hF) begin
            state_q <= IDLE;
          end else begin
            vec_id_q    <= enc_code[3:0];
            vec_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (vec.vec_ready) begin
            vec_valid_q <= 1'b0;
            if (HOLDOFF == 0) begin
              state_q <= IDLE;
            end else begin
              hold_q  <= HoldLoad;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_q == 4'd0) state_q <= IDLE;
          else                hold_q  <= hold_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enc_req       = pending_q & mask;
  assign pending       = pending_q;
  assign overflow      = overflow_q;
  assign vec.vec_valid = vec_valid_q;
  assign vec.vec_id    = vec_id_q;

endmodule
